// File: rtl/uart_cmd_if.sv
// uart_cmd_if: byte stream in, register-write request and status out
interface uart_cmd_if;
   logic [7:0] rx_data;
   logic       rx_vld;
   logic       wr_vld;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic       wr_rdy;
   logic       busy;
   logic       err_chk;
   logic       err_tmo;
   logic       err_ovf;
   logic [7:0] ok_cnt;
   modport master (output rx_data, rx_vld, wr_rdy,
                   input  wr_vld, wr_addr, wr_data, busy, err_chk, err_tmo, err_ovf, ok_cnt);
   modport slave  (input  rx_data, rx_vld, wr_rdy,
                   output wr_vld, wr_addr, wr_data, busy, err_chk, err_tmo, err_ovf, ok_cnt);
endinterface

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: parses HDR,ADDR,DATA,CHK frames into register writes
module uart_cmd_ctrl #(
   parameter logic [7:0]  HDR     = 8'hA5,
   parameter int unsigned TIMEOUT = 21700
) (
   input logic        clk,
   input logic        rst,
   uart_cmd_if.slave  bus
);
   typedef enum logic [2:0] {IDLE, GET_ADDR, GET_DATA, GET_CHK, ISSUE} state_t;
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
   state_t      state_q, state_d;
   logic [7:0]  addr_q, addr_d, data_q, data_d;
   logic [7:0]  wr_addr_q, wr_addr_d, wr_data_q, wr_data_d, ok_cnt_q, ok_cnt_d;
   logic [15:0] tmo_q, tmo_d;
   logic        wr_vld_q, wr_vld_d, busy_q, busy_d;
   logic        err_chk_q, err_chk_d, err_tmo_q, err_tmo_d, err_ovf_q, err_ovf_d;
   logic        in_get;
   assign in_get = state_q inside {GET_ADDR, GET_DATA, GET_CHK};
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      data_d    = data_q;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      wr_vld_d  = wr_vld_q;
      ok_cnt_d  = ok_cnt_q;
      err_chk_d = 1'b0;
      err_tmo_d = 1'b0;
      err_ovf_d = 1'b0;
      tmo_d     = (bus.rx_vld || !in_get) ? 16'd0 : tmo_q + 16'd1;
      case (state_q)
         IDLE:     if (bus.rx_vld && bus.rx_data == HDR) state_d = GET_ADDR;
         GET_ADDR: if (bus.rx_vld) begin
            addr_d  = bus.rx_data;
            state_d = GET_DATA;
         end
         GET_DATA: if (bus.rx_vld) begin
            data_d  = bus.rx_data;
            state_d = GET_CHK;
         end
         GET_CHK:  if (bus.rx_vld) begin
            if (bus.rx_data == (HDR ^ addr_q ^ data_q)) begin
               state_d   = ISSUE;
               wr_vld_d  = 1'b1;
               wr_addr_d = addr_q;
               wr_data_d = data_q;
               ok_cnt_d  = ok_cnt_q + 8'd1;
            end else begin
               state_d   = IDLE;
               err_chk_d = 1'b1;
            end
         end
         ISSUE: begin
            // a byte arriving here is always dropped, even on the handshake cycle
            err_ovf_d = bus.rx_vld;
            if (bus.wr_rdy) begin
               state_d  = IDLE;
               wr_vld_d = 1'b0;
            end
         end
         default:  state_d = IDLE;
      endcase
      if (in_get && !bus.rx_vld && tmo_q == TMO_LAST) begin
         state_d   = IDLE;
         err_tmo_d = 1'b1;
      end
      busy_d = state_d != IDLE;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         data_q    <= '0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         wr_vld_q  <= 1'b0;
         ok_cnt_q  <= '0;
         tmo_q     <= '0;
         busy_q    <= 1'b0;
         err_chk_q <= 1'b0;
         err_tmo_q <= 1'b0;
         err_ovf_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         wr_vld_q  <= wr_vld_d;
         ok_cnt_q  <= ok_cnt_d;
         tmo_q     <= tmo_d;
         busy_q    <= busy_d;
         err_chk_q <= err_chk_d;
         err_tmo_q <= err_tmo_d;
         err_ovf_q <= err_ovf_d;
      end
   end
   assign bus.wr_vld  = wr_vld_q;
   assign bus.wr_addr = wr_addr_q;
   assign bus.wr_data = wr_data_q;
   assign bus.busy    = busy_q;
   assign bus.err_chk = err_chk_q;
   assign bus.err_tmo = err_tmo_q;
   assign bus.err_ovf = err_ovf_q;
   assign bus.ok_cnt  = ok_cnt_q;
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl: directed frame scenarios against hand-computed expectations
module tb_uart_cmd_ctrl;
   localparam int TMO = 40;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int errors = 0, checks = 0;
   int n_wr = 0, n_chk = 0, n_tmo = 0, n_ovf = 0;
   always #5 clk = ~clk;
   uart_cmd_if bus();
   uart_cmd_ctrl #(.HDR(8'hA5), .TIMEOUT(TMO)) dut (.clk(clk), .rst(rst), .bus(bus));
   always @(negedge clk) begin
      if (bus.wr_vld && bus.wr_rdy) n_wr++;
      if (bus.err_chk) n_chk++;
      if (bus.err_tmo) n_tmo++;
      if (bus.err_ovf) n_ovf++;
   end
   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic send(input logic [7:0] b);
      bus.rx_data = b;
      bus.rx_vld  = 1'b1;
      step();
      bus.rx_vld  = 1'b0;
   endtask
   task automatic frame(input logic [7:0] a, input logic [7:0] d);
      send(8'hA5);
      send(a);
      send(d);
      send(8'hA5 ^ a ^ d);
   endtask
   task automatic test_reset;
      #3;
      checks++; if (bus.wr_vld !== 1'b0) begin errors++; $display("FAIL rst_wr_vld: got %b want 0", bus.wr_vld); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
      checks++; if ({bus.err_chk, bus.err_tmo, bus.err_ovf} !== 3'b000) begin errors++; $display("FAIL rst_err: got %b want 000", {bus.err_chk, bus.err_tmo, bus.err_ovf}); end
      checks++; if ({bus.wr_addr, bus.wr_data, bus.ok_cnt} !== 24'h0) begin errors++; $display("FAIL rst_regs: got %h want 000000", {bus.wr_addr, bus.wr_data, bus.ok_cnt}); end
      step(2);
      rst = 1'b0;
      step();
   endtask
   task automatic test_valid_frame;
      bus.wr_rdy = 1'b1;
      send(8'hA5); send(8'h12); send(8'h34); send(8'h83);
      checks++; if (bus.wr_vld !== 1'b1) begin errors++; $display("FAIL vf_wr_vld: got %b want 1", bus.wr_vld); end
      checks++; if ({bus.wr_addr, bus.wr_data} !== 16'h1234) begin errors++; $display("FAIL vf_addr_data: got %h want 1234", {bus.wr_addr, bus.wr_data}); end
      checks++; if (bus.ok_cnt !== 8'd1) begin errors++; $display("FAIL vf_ok_cnt: got %0d want 1", bus.ok_cnt); end
      step();
      checks++; if ({bus.wr_vld, bus.busy} !== 2'b00) begin errors++; $display("FAIL vf_done: got %b want 00", {bus.wr_vld, bus.busy}); end
      checks++; if (n_wr !== 1) begin errors++; $display("FAIL vf_n_wr: got %0d want 1", n_wr); end
      checks++; if (n_chk + n_tmo + n_ovf !== 0) begin errors++; $display("FAIL vf_no_err: got %0d want 0", n_chk + n_tmo + n_ovf); end
   endtask
   task automatic test_back_to_back;
      logic [7:0] ok0, a;
      int wr0, e0, bad;
      ok0 = bus.ok_cnt; wr0 = n_wr; e0 = n_chk + n_tmo + n_ovf; bad = 0;
      bus.wr_rdy = 1'b1;
      for (int i = 0; i < 256; i++) begin
         a = 8'(i);
         send(8'h00); send(8'hFF); send(8'h12);
         frame(a, ~a);
         if (!(bus.wr_vld === 1'b1 && bus.wr_addr === a && bus.wr_data === ~a)) bad++;
         step();
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL b2b_writes: got %0d bad want 0", bad); end
      checks++; if (n_wr - wr0 !== 256) begin errors++; $display("FAIL b2b_n_wr: got %0d want 256", n_wr - wr0); end
      checks++; if (bus.ok_cnt !== ok0) begin errors++; $display("FAIL b2b_ok_wrap: got %0d want %0d", bus.ok_cnt, ok0); end
      checks++; if (n_chk + n_tmo + n_ovf - e0 !== 0) begin errors++; $display("FAIL b2b_no_err: got %0d want 0", n_chk + n_tmo + n_ovf - e0); end
      frame(8'h11, 8'h22);
      step();
      frame(8'h33, 8'h44);
      checks++; if ({bus.wr_vld, bus.wr_addr, bus.wr_data} !== 17'h13344) begin errors++; $display("FAIL b2b_zero_dead: got %h want 13344", {bus.wr_vld, bus.wr_addr, bus.wr_data}); end
      step();
   endtask
   task automatic test_bad_chk;
      logic [7:0] ok0;
      int wr0, c0;
      ok0 = bus.ok_cnt; wr0 = n_wr; c0 = n_chk;
      send(8'hA5); send(8'h12); send(8'h34); send(8'h00);
      checks++; if ({bus.err_chk, bus.wr_vld, bus.busy} !== 3'b100) begin errors++; $display("FAIL chk_pulse: got %b want 100", {bus.err_chk, bus.wr_vld, bus.busy}); end
      step();
      checks++; if (bus.err_chk !== 1'b0) begin errors++; $display("FAIL chk_single: got %b want 0", bus.err_chk); end
      checks++; if (bus.ok_cnt !== ok0) begin errors++; $display("FAIL chk_ok_cnt: got %0d want %0d", bus.ok_cnt, ok0); end
      checks++; if (n_wr - wr0 !== 0 || n_chk - c0 !== 1) begin errors++; $display("FAIL chk_counts: got wr=%0d chk=%0d want 0 1", n_wr - wr0, n_chk - c0); end
   endtask
   task automatic test_timeout;
      int t0;
      t0 = n_tmo;
      send(8'hA5); send(8'h12);
      step(TMO - 1);
      checks++; if ({bus.err_tmo, bus.busy} !== 2'b01) begin errors++; $display("FAIL tmo_before: got %b want 01", {bus.err_tmo, bus.busy}); end
      step();
      checks++; if ({bus.err_tmo, bus.busy} !== 2'b10) begin errors++; $display("FAIL tmo_pulse: got %b want 10", {bus.err_tmo, bus.busy}); end
      step();
      checks++; if (bus.err_tmo !== 1'b0) begin errors++; $display("FAIL tmo_single: got %b want 0", bus.err_tmo); end
      send(8'hA5); send(8'h01); send(8'h02); send(8'hA6);
      checks++; if ({bus.wr_vld, bus.wr_addr, bus.wr_data} !== 17'h10102) begin errors++; $display("FAIL tmo_recover: got %h want 10102", {bus.wr_vld, bus.wr_addr, bus.wr_data}); end
      step();
      send(8'hA5);
      step(TMO - 1);
      send(8'h12);
      checks++; if ({bus.err_tmo, bus.busy} !== 2'b01) begin errors++; $display("FAIL tmo_edge_taken: got %b want 01", {bus.err_tmo, bus.busy}); end
      send(8'h34); send(8'h83);
      checks++; if ({bus.wr_vld, bus.wr_addr, bus.wr_data} !== 17'h11234) begin errors++; $display("FAIL tmo_edge_write: got %h want 11234", {bus.wr_vld, bus.wr_addr, bus.wr_data}); end
      step();
      checks++; if (n_tmo - t0 !== 1) begin errors++; $display("FAIL tmo_count: got %0d want 1", n_tmo - t0); end
   endtask
   task automatic test_backpressure;
      logic [7:0] ok0;
      int wr0, o0, bad;
      ok0 = bus.ok_cnt; wr0 = n_wr; o0 = n_ovf; bad = 0;
      bus.wr_rdy = 1'b0;
      frame(8'h56, 8'h78);
      for (int i = 0; i < 50; i++) begin
         if (i == 10) send(8'h55); else step();
         if (i == 10) begin
            checks++; if (bus.err_ovf !== 1'b1) begin errors++; $display("FAIL bp_ovf: got %b want 1", bus.err_ovf); end
         end
         if (!(bus.wr_vld === 1'b1 && bus.busy === 1'b1 && bus.wr_addr === 8'h56 && bus.wr_data === 8'h78)) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL bp_stable: got %0d bad cycles want 0", bad); end
      checks++; if (n_wr - wr0 !== 0) begin errors++; $display("FAIL bp_no_early_wr: got %0d want 0", n_wr - wr0); end
      bus.wr_rdy = 1'b1;
      step();
      checks++; if ({bus.wr_vld, bus.busy} !== 2'b00) begin errors++; $display("FAIL bp_done: got %b want 00", {bus.wr_vld, bus.busy}); end
      checks++; if (n_wr - wr0 !== 1 || n_ovf - o0 !== 1) begin errors++; $display("FAIL bp_counts: got wr=%0d ovf=%0d want 1 1", n_wr - wr0, n_ovf - o0); end
      checks++; if (bus.ok_cnt !== ok0 + 8'd1) begin errors++; $display("FAIL bp_ok_cnt: got %0d want %0d", bus.ok_cnt, ok0 + 8'd1); end
   endtask
   task automatic test_ovf_handshake;
      bus.wr_rdy = 1'b0;
      frame(8'h9A, 8'hBC);
      bus.wr_rdy = 1'b1;
      send(8'hA5);
      checks++; if ({bus.wr_vld, bus.err_ovf, bus.busy} !== 3'b010) begin errors++; $display("FAIL ovfhs_pulse: got %b want 010", {bus.wr_vld, bus.err_ovf, bus.busy}); end
      send(8'h01);
      checks++; if ({bus.busy, bus.err_ovf} !== 2'b00) begin errors++; $display("FAIL ovfhs_dropped: got %b want 00", {bus.busy, bus.err_ovf}); end
   endtask
   task automatic test_reset_mid;
      int wr0;
      wr0 = n_wr;
      send(8'hA5); send(8'h12);
      rst = 1'b1;
      #2;
      checks++; if ({bus.busy, bus.ok_cnt} !== 9'h0) begin errors++; $display("FAIL rstmid_busy_ok: got %h want 000", {bus.busy, bus.ok_cnt}); end
      rst = 1'b0;
      step();
      bus.wr_rdy = 1'b0;
      frame(8'h77, 8'h88);
      rst = 1'b1;
      #2;
      checks++; if ({bus.wr_vld, bus.busy, bus.wr_addr, bus.wr_data} !== 18'h0) begin errors++; $display("FAIL rstmid_issue: got %h want 0", {bus.wr_vld, bus.busy, bus.wr_addr, bus.wr_data}); end
      rst = 1'b0;
      step();
      checks++; if (n_wr - wr0 !== 0) begin errors++; $display("FAIL rstmid_no_wr: got %0d want 0", n_wr - wr0); end
      bus.wr_rdy = 1'b1;
      frame(8'h5C, 8'h3D);
      step(3);
      checks++; if (n_wr - wr0 !== 1 || bus.ok_cnt !== 8'd1) begin errors++; $display("FAIL rstmid_one_wr: got wr=%0d ok=%0d want 1 1", n_wr - wr0, bus.ok_cnt); end
   endtask
   initial begin
      bus.rx_data = 8'h00;
      bus.rx_vld  = 1'b0;
      bus.wr_rdy  = 1'b1;
      test_reset();
      test_valid_frame();
      test_back_to_back();
      test_bad_chk();
      test_timeout();
      test_backpressure();
      test_ovf_handshake();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/uart_cmd_ctrl.md
UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 Parameter HDR, default 8'hA5, frame header byte.
REQ-002 Parameter TIMEOUT, default 21700, maximum inter-byte gap in clk cycles (about 10 byte times at 460800 baud, 100 MHz).
REQ-003 clk  input  1  system clock, 100 MHz, all logic on rising edge.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 rx_data  input  8  received byte from the UART receiver.
REQ-006 rx_vld  input  1  single-cycle strobe; rx_data is valid in this cycle.
REQ-007 wr_vld  output  1  register-write request.
REQ-008 wr_addr  output  8  register-write address.
REQ-009 wr_data  output  8  register-write data.
REQ-010 wr_rdy  input  1  downstream accepts the write.
REQ-011 busy  output  1  high whenever the state is not IDLE.
REQ-012 err_chk  output  1  single-cycle pulse on a checksum mismatch.
REQ-013 err_tmo  output  1  single-cycle pulse on an inter-byte timeout.
REQ-014 err_ovf  output  1  single-cycle pulse when a byte arrives while a write is pending.
REQ-015 ok_cnt  output  8  count of accepted frames, wraps from 255 to 0.

Function
REQ-016 Frame format SHALL be HDR, ADDR, DATA, CHK, with CHK = HDR ^ ADDR ^ DATA.
REQ-017 The FSM SHALL have states IDLE, GET_ADDR, GET_DATA, GET_CHK and ISSUE.
REQ-018 IDLE: rx_vld with rx_data==HDR -> GET_ADDR; any other byte is discarded silently.
REQ-019 GET_ADDR: rx_vld latches rx_data into the address holding register -> GET_DATA.
REQ-020 GET_DATA: rx_vld latches rx_data into the data holding register -> GET_CHK.
REQ-021 GET_CHK on a match: rx_vld with a matching checksum -> ISSUE, wr_vld=1 from the next cycle, and ok_cnt increments by 1 in the same cycle as the transition.
REQ-022 GET_CHK on a mismatch: rx_vld with a mismatching checksum -> IDLE, err_chk pulses for one cycle on the next cycle, and no write is issued.
REQ-023 ISSUE: wr_vld, wr_addr and wr_data SHALL stay stable until the cycle in which wr_vld && wr_rdy holds, then go to IDLE with wr_vld=0 on the next cycle.
REQ-024 ISSUE: an rx_vld SHALL drop the byte and pulse err_ovf on the next cycle; the state is unchanged.
REQ-025 ISSUE: if rx_vld and the handshake occur in the same cycle, the write completes, err_ovf pulses, and the byte is dropped (it is not treated as HDR).
REQ-026 wr_addr and wr_data SHALL update only on the entry to ISSUE.
REQ-027 Timeout counter, 16 bits: cleared on every rx_vld and in IDLE and ISSUE; increments each cycle in GET_ADDR, GET_DATA and GET_CHK.
REQ-028 When the timeout counter reaches TIMEOUT-1 without an rx_vld, the FSM SHALL go to IDLE and err_tmo SHALL pulse on the next cycle.
REQ-029 If rx_vld coincides with the TIMEOUT-1 cycle, the byte is taken and no timeout occurs.
REQ-030 A new frame SHALL be accepted in the first IDLE cycle after ISSUE ends (zero dead cycles).
REQ-031 The error pulses are mutually exclusive except as allowed by REQ-025; all outputs are registered.

Reset
REQ-032 While rst=1: state=IDLE, and wr_vld, busy, err_chk, err_tmo and err_ovf are 0.
REQ-033 While rst=1: wr_addr, wr_data, ok_cnt and the timeout counter are 0.
REQ-034 Reset asserted mid-frame or in ISSUE SHALL abort immediately; the partial frame is discarded and wr_vld drops asynchronously.
REQ-035 After rst deasserts, the first valid HDR byte starts a frame normally.

Verification
REQ-036 Bytes A5,12,34,83 with wr_rdy=1 -> one wr_vld cycle with wr_addr=12, wr_data=34; ok_cnt becomes 1; no error pulse.
REQ-037 Bytes A5,12,34,00 -> err_chk single pulse, no wr_vld, ok_cnt unchanged, busy=0 afterwards.
REQ-038 Byte A5, then 12, then silence for TIMEOUT cycles -> err_tmo pulse at the timeout, state IDLE; next bytes A5,01,02,A6 -> write addr 01, data 02.
REQ-039 Valid frame with wr_rdy=0 for 50 cycles, plus a byte 55 during the wait -> wr_vld held with stable addr and data, err_ovf pulse, write completes when wr_rdy rises, byte 55 is lost.
REQ-040 Garbage bytes 00,FF,12, then a valid frame, repeated 256 times back-to-back -> 256 writes and ok_cnt wraps to 0.
REQ-041 rst asserted after A5,12 -> busy=0 immediately, ok_cnt=0, no write; then a full valid frame -> exactly one write.
